issue_scheduler: RTL and testbench

Issue controller between the decode stage and the two execution pipelines: the ALU/memory pipe and the multi-cycle multiply pipe. It tracks every in-flight register write in a writeback reservation shift register. It stalls decode on read-after-write or write-after-write hazards against in-flight multiplies, and on conflicts for the single regfile write port. It also names the pipe that owns the write port each cycle. It complements the decode-stage hazard unit, which covers ALU-pipe hazards only.

---
 rtl/issue_scheduler_pkg.sv | 28 ++
 rtl/issue_scheduler_wb_reservation_ring.sv | 69 ++++++
 rtl/issue_scheduler.sv | 92 +++++++++
 tb/tb_issue_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: register address width, default
// pipe latencies and the writeback reservation slot layout.
package issue_scheduler_pkg;

  localparam int unsigned RegAddr       = 5;
  localparam int unsigned MulLatDefault = 5;
  localparam int unsigned AluLatDefault = 3;

  typedef logic [RegAddr-1:0] reg_addr_t;

  // One writeback reservation: a write happens k cycles from now when slot[k].valid.
  typedef struct packed {
    logic      valid;
    logic      from_mul;
    reg_addr_t dest;
  } slot_t;

  localparam slot_t SlotEmpty = '0;

  function automatic slot_t make_slot(input logic from_mul, input reg_addr_t dest);
    slot_t s;
    s.valid    = 1'b1;
    s.from_mul = from_mul;
    s.dest     = dest;
    return s;
  endfunction

endpackage

// File: rtl/issue_scheduler_wb_reservation_ring.sv
// wb_reservation_ring: writeback reservation shift register.
//   clk_i, rst_i           clock, asynchronous active-high reset
//   alu_wr_i / mul_wr_i    reserve slot ALU_LAT-1 / MUL_LAT-1 for wr_dest_i this edge
//   cmp_src1_i/src2_i/dest_i  addresses compared against every slot
//   slot0_*_o              slot 0 contents (the write happening this cycle)
//   valid_o                per-slot valid
//   hit_*_o                per-slot: valid multiply entry whose dest matches the address
module wb_reservation_ring
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned ALU_LAT = AluLatDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alu_wr_i,
  input  logic               mul_wr_i,
  input  logic [RegAddr-1:0] wr_dest_i,
  input  logic [RegAddr-1:0] cmp_src1_i,
  input  logic [RegAddr-1:0] cmp_src2_i,
  input  logic [RegAddr-1:0] cmp_dest_i,
  output logic               slot0_valid_o,
  output logic               slot0_from_mul_o,
  output logic [RegAddr-1:0] slot0_dest_o,
  output logic [MUL_LAT-1:0] valid_o,
  output logic [MUL_LAT-1:0] hit_src1_o,
  output logic [MUL_LAT-1:0] hit_src2_o,
  output logic [MUL_LAT-1:0] hit_dest_o
);

  slot_t slot_q [MUL_LAT];
  slot_t slot_d [MUL_LAT];

  always_comb begin
    for (int unsigned k = 0; k < MUL_LAT - 1; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[MUL_LAT-1] = SlotEmpty;
    // The scheduler has already checked slot ALU_LAT, so this never overwrites a live entry.
    if (alu_wr_i) slot_d[ALU_LAT-1] = make_slot(1'b0, wr_dest_i);
    if (mul_wr_i) slot_d[MUL_LAT-1] = make_slot(1'b1, wr_dest_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < MUL_LAT; k++) slot_q[k] <= SlotEmpty;
    end else begin
      for (int unsigned k = 0; k < MUL_LAT; k++) slot_q[k] <= slot_d[k];
    end
  end

  always_comb begin
    valid_o    = '0;
    hit_src1_o = '0;
    hit_src2_o = '0;
    hit_dest_o = '0;
    for (int unsigned k = 0; k < MUL_LAT; k++) begin
      valid_o[k]    = slot_q[k].valid;
      hit_src1_o[k] = slot_q[k].valid & slot_q[k].from_mul & (slot_q[k].dest == cmp_src1_i);
      hit_src2_o[k] = slot_q[k].valid & slot_q[k].from_mul & (slot_q[k].dest == cmp_src2_i);
      hit_dest_o[k] = slot_q[k].valid & slot_q[k].from_mul & (slot_q[k].dest == cmp_dest_i);
    end
  end

  assign slot0_valid_o    = slot_q[0].valid;
  assign slot0_from_mul_o = slot_q[0].from_mul;
  assign slot0_dest_o     = slot_q[0].dest;

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: issue control between decode and the ALU/memory and multiply pipes.
//   clk, reset                      clock, asynchronous active-high reset
//   id_valid, id_flush              decode instruction present / killed this cycle
//   id_is_mult, id_regwrite         target pipe / writes the regfile
//   id_dest_reg, id_src1, id_src2   register addresses of the decode instruction
//   stall, issue_alu, issue_mul     combinational decode handshake
//   wb_valid, wb_from_mul, wb_dest  registered write-port control (from slot 0)
//   mul_inflight                    registered count of outstanding multiplies
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MulLatDefault,
  parameter int unsigned ALU_LAT  = AluLatDefault,
  parameter int unsigned REG_ADDR = RegAddr
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                id_flush,
  input  logic                id_is_mult,
  input  logic                id_regwrite,
  input  logic [REG_ADDR-1:0] id_dest_reg,
  input  logic [REG_ADDR-1:0] id_src1,
  input  logic [REG_ADDR-1:0] id_src2,
  output logic                stall,
  output logic                issue_alu,
  output logic                issue_mul,
  output logic                wb_valid,
  output logic                wb_from_mul,
  output logic [REG_ADDR-1:0] wb_dest,
  output logic [2:0]          mul_inflight
);

  logic [MUL_LAT-1:0] slot_valid;
  logic [MUL_LAT-1:0] hit_src1;
  logic [MUL_LAT-1:0] hit_src2;
  logic [MUL_LAT-1:0] hit_dest;
  logic               req, raw, waw, port;
  logic               mul_retire;
  logic [2:0]         mul_inflight_q, mul_inflight_d;

  wb_reservation_ring #(
    .MUL_LAT (MUL_LAT),
    .ALU_LAT (ALU_LAT)
  ) u_ring (
    .clk_i            (clk),
    .rst_i            (reset),
    .alu_wr_i         (issue_alu & id_regwrite),
    .mul_wr_i         (issue_mul),
    .wr_dest_i        (id_dest_reg),
    .cmp_src1_i       (id_src1),
    .cmp_src2_i       (id_src2),
    .cmp_dest_i       (id_dest_reg),
    .slot0_valid_o    (wb_valid),
    .slot0_from_mul_o (wb_from_mul),
    .slot0_dest_o     (wb_dest),
    .valid_o          (slot_valid),
    .hit_src1_o       (hit_src1),
    .hit_src2_o       (hit_src2),
    .hit_dest_o       (hit_dest)
  );

  always_comb begin
    req  = id_valid & ~id_flush;
    // Slot 0 is being written this cycle and the regfile writes before it is read,
    // so a source only hazards against multiplies still further out.
    raw  = ((|hit_src1[MUL_LAT-1:1]) & (id_src1 != '0)) |
           ((|hit_src2[MUL_LAT-1:1]) & (id_src2 != '0));
    waw  = id_regwrite & (id_dest_reg != '0) & (|hit_dest);
    // Occupancy before the shift: slot ALU_LAT lands in ALU_LAT-1 on this edge.
    port = ~id_is_mult & id_regwrite & slot_valid[ALU_LAT];
    stall     = req & (raw | waw | port);
    issue_alu = req & ~stall & ~id_is_mult;
    issue_mul = req & ~stall & id_is_mult;
  end

  assign mul_retire = wb_valid & wb_from_mul;

  always_comb begin
    mul_inflight_d = mul_inflight_q;
    if (issue_mul && !mul_retire)      mul_inflight_d = mul_inflight_q + 3'd1;
    else if (!issue_mul && mul_retire) mul_inflight_d = mul_inflight_q - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mul_inflight_q <= '0;
    else       mul_inflight_q <= mul_inflight_d;
  end

  assign mul_inflight = mul_inflight_q;

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

  localparam int MulLat = 5;
  localparam int AluLat = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_flush, id_is_mult, id_regwrite;
  logic [4:0] id_dest_reg, id_src1, id_src2;
  logic       stall, issue_alu, issue_mul;
  logic       wb_valid, wb_from_mul;
  logic [4:0] wb_dest;
  logic [2:0] mul_inflight;

  issue_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_flush     (id_flush),
    .id_is_mult   (id_is_mult),
    .id_regwrite  (id_regwrite),
    .id_dest_reg  (id_dest_reg),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .stall        (stall),
    .issue_alu    (issue_alu),
    .issue_mul    (issue_mul),
    .wb_valid     (wb_valid),
    .wb_from_mul  (wb_from_mul),
    .wb_dest      (wb_dest),
    .mul_inflight (mul_inflight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit mul; int dest; int cyc; } wb_t;
  typedef struct { bit mul; int cyc; } iss_t;
  wb_t  wb_q[$];
  iss_t iss_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expected issues and writebacks whenever the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = wb_q.size() - 1; i >= 0; i--) begin
        if (wb_q[i].cyc < cyc) begin
          check("wb_missed_at_cycle", cyc, wb_q[i].cyc);
          wb_q.delete(i);
        end
      end
      if (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        check("issue_missed_at_cycle", cyc, iss_q[0].cyc);
        void'(iss_q.pop_front());
      end
      if (wb_valid) begin
        int idx = -1;
        for (int i = 0; i < wb_q.size(); i++) if (wb_q[i].cyc == cyc) idx = i;
        if (idx < 0) begin
          check("wb_unexpected", int'(wb_valid), 0);
        end else begin
          check("wb_from_mul", int'(wb_from_mul), int'(wb_q[idx].mul));
          check("wb_dest", int'(wb_dest), wb_q[idx].dest);
          wb_q.delete(idx);
        end
      end
      if (issue_alu || issue_mul) begin
        if (iss_q.size() == 0 || iss_q[0].cyc != cyc) begin
          check("issue_unexpected", int'(issue_alu | issue_mul), 0);
        end else begin
          check("issue_mul", int'(issue_mul), int'(iss_q[0].mul));
          check("issue_alu", int'(issue_alu), int'(!iss_q[0].mul));
          void'(iss_q.pop_front());
        end
      end
    end
  end

  // One decode cycle with a hand-computed expected stall.
  task automatic step(input bit v, input bit fl, input bit m, input bit rw,
                      input int d, input int s1, input int s2, input bit exp_stall);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_flush    = fl;
    id_is_mult  = m;
    id_regwrite = rw;
    id_dest_reg = 5'(d);
    id_src1     = 5'(s1);
    id_src2     = 5'(s2);
    if (v && !fl && !exp_stall) begin
      iss_q.push_back('{m, cyc});
      if (m || rw) wb_q.push_back('{m, d, cyc + (m ? MulLat : AluLat)});
    end
    @(negedge clk);
    check("stall", int'(stall), int'(exp_stall));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_flush = 0; id_is_mult = 0; id_regwrite = 0;
    id_dest_reg = 0; id_src1 = 0; id_src2 = 0;
    @(negedge clk);
    check("reset_wb_valid", int'(wb_valid), 0);
    check("reset_wb_from_mul", int'(wb_from_mul), 0);
    check("reset_wb_dest", int'(wb_dest), 0);
    check("reset_mul_inflight", int'(mul_inflight), 0);
    check("reset_stall", int'(stall), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // 1: write-port conflict, ALU yields one cycle; writes mul r4 @5 then alu r7 @6.
    step(1, 0, 1, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_inflight", int'(mul_inflight), 1);
    step(1, 0, 0, 1, 7, 1, 2, 1);
    step(1, 0, 0, 1, 7, 1, 2, 0);
    idle(8);

    // 2: RAW on r4, stall cycles 1-4, issue at 5.
    step(1, 0, 1, 1, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 9, 4, 0, 1);
    step(1, 0, 0, 1, 9, 4, 0, 0);
    idle(8);

    // 3: WAW on r4, held while the multiply slot is live, ALU writes after it.
    step(1, 0, 1, 1, 4, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 4, 0, 0, 1);
    step(1, 0, 0, 1, 4, 0, 0, 0);
    idle(8);

    // 4: back-to-back multiplies, plus an issue coinciding with a retire.
    step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 2, 0, 0, 0);
    step(1, 0, 1, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_inflight_peak", int'(mul_inflight), 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_inflight_issue_and_retire", int'(mul_inflight), 3);
    idle(6);
    check("t4_inflight_drained", int'(mul_inflight), 0);
    idle(2);

    // 5: register 0 never hazards.
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3, 0, 0, 0);
    idle(8);

    // 6: flush over a hazard, then reset with two multiplies in flight.
    step(1, 0, 1, 1, 4, 0, 0, 0);
    step(1, 1, 0, 1, 9, 4, 0, 0);
    step(1, 0, 0, 1, 9, 4, 0, 1);
    step(1, 0, 1, 1, 6, 0, 0, 0);
    @(posedge clk);
    #1;
    id_valid = 0; id_flush = 0; id_is_mult = 0; id_regwrite = 0;
    check("t6_inflight_pre_reset", int'(mul_inflight), 2);
    reset = 1'b1;
    #1;
    check("t6_reset_wb_valid", int'(wb_valid), 0);
    check("t6_reset_inflight", int'(mul_inflight), 0);
    check("t6_reset_stall", int'(stall), 0);
    wb_q.delete();
    iss_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(8);
    check("t6_inflight_after", int'(mul_inflight), 0);

    check("wb_queue_left", wb_q.size(), 0);
    check("issue_queue_left", iss_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
